// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_monitor
// Description : Watches a divided clock (div_in) as data in the source clk
//               domain. Measures each period and its high time in clk cycles.
//               Declares lock after LOCK_CNT consecutive in-tolerance periods.
//               Raises a sticky fault when a period is out of tolerance, or
//               when div_in stops toggling, after lock has been reached.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N         expected divide factor (div_in period in clk cycles), N >= 2
//   TOL       allowed |period - N| in clk cycles
//   LOCK_CNT  consecutive good periods needed to lock, 1..15
//   CW        measurement counter width, 2^CW > 2*N+TOL+1
// Ports
//   clk          in   source clock; the clock that also drives the divider
//   rst          in   asynchronous reset, active low
//   en           in   monitor enable; low returns to IDLE
//   clr_fault    in   single-cycle pulse; leaves FAULT and resynchronises
//   div_in       in   divided clock, synchronous to clk
//   period_meas  out  last measured period (clk cycles)
//   high_meas    out  high cycles within the last measured period
//   period_valid out  one-cycle pulse when the measurements update
//   locked       out  lock status
//   fault        out  sticky fault status
//   fault_cause  out  01 = period out of tolerance, 10 = div_in stuck
//   err_count    out  saturating count of bad-period and timeout events
// ============================================================================
module clk_div_monitor #(
    parameter int N        = 4,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr_fault,
    input  logic          div_in,
    output logic [CW-1:0] period_meas,
    output logic [CW-1:0] high_meas,
    output logic          period_valid,
    output logic          locked,
    output logic          fault,
    output logic [1:0]    fault_cause,
    output logic [7:0]    err_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_MEASURE = 3'd2,
        S_LOCKED  = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    // A period this long without a rise means div_in has stopped toggling.
    localparam logic [CW-1:0]        C_TIMEOUT = CW'(2 * N + TOL + 1);
    localparam logic signed [CW:0]   C_N_S     = (CW + 1)'(N);
    localparam logic signed [CW:0]   C_TOL_S   = (CW + 1)'(TOL);
    localparam logic [3:0]           C_LOCK    = 4'(LOCK_CNT);
    localparam logic [1:0]           C_CAUSE_PERIOD  = 2'b01;
    localparam logic [1:0]           C_CAUSE_TIMEOUT = 2'b10;

    state_t          state_q, state_d;
    logic            div_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   hcnt_q, hcnt_d;
    logic [3:0]      good_cnt_q, good_cnt_d;
    logic [CW-1:0]   period_meas_q, period_meas_d;
    logic [CW-1:0]   high_meas_q, high_meas_d;
    logic            period_valid_q, period_valid_d;
    logic            locked_q, locked_d;
    logic            fault_q, fault_d;
    logic [1:0]      fault_cause_q, fault_cause_d;
    logic [7:0]      err_count_q, err_count_d;

    logic            w_rise;
    logic            w_timeout;
    logic            w_good;
    logic            w_err_event;
    logic signed [CW:0] w_diff;
    logic signed [CW:0] w_abs;
    logic [3:0]      w_good_inc;

    assign w_rise     = div_in & ~div_q;
    // A rise in the timeout cycle wins: that period is measured (and is bad).
    assign w_timeout  = (cnt_q == C_TIMEOUT) & ~w_rise;
    assign w_diff     = $signed({1'b0, cnt_q}) - C_N_S;
    assign w_abs      = w_diff[CW] ? -w_diff : w_diff;
    assign w_good     = (w_abs <= C_TOL_S);
    assign w_good_inc = good_cnt_q + 4'd1;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hcnt_d         = hcnt_q;
        good_cnt_d     = good_cnt_q;
        period_meas_d  = period_meas_q;
        high_meas_d    = high_meas_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        fault_d        = fault_q;
        fault_cause_d  = fault_cause_q;
        w_err_event    = 1'b0;

        if (!en) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            hcnt_d        = '0;
            good_cnt_d    = '0;
            locked_d      = 1'b0;
            fault_d       = 1'b0;
            fault_cause_d = 2'b00;
        end else begin
            // Counters stay at zero in IDLE and start counting from SYNC on.
            if (state_q != S_IDLE) begin
                if (w_rise || w_timeout) begin
                    cnt_d = CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (w_rise) begin
                    hcnt_d = CW'(1);
                end else if (div_in) begin
                    hcnt_d = hcnt_q + CW'(1);
                end
            end

            // The edge that leaves SYNC only aligns the counters; every
            // later rise closes a full period and is reported.
            if (w_rise && (state_q == S_MEASURE || state_q == S_LOCKED ||
                           state_q == S_FAULT)) begin
                period_meas_d  = cnt_q;
                high_meas_d    = hcnt_q;
                period_valid_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    state_d = S_SYNC;
                end
                S_SYNC: begin
                    if (w_rise) begin
                        state_d = S_MEASURE;
                    end else if (w_timeout) begin
                        w_err_event = 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (w_rise && w_good) begin
                        good_cnt_d = w_good_inc;
                        if (w_good_inc == C_LOCK) begin
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (w_rise || w_timeout) begin
                        good_cnt_d  = '0;
                        w_err_event = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_rise && !w_good) begin
                        state_d       = S_FAULT;
                        locked_d      = 1'b0;
                        fault_d       = 1'b1;
                        fault_cause_d = C_CAUSE_PERIOD;
                        w_err_event   = 1'b1;
                    end else if (w_timeout) begin
                        state_d       = S_FAULT;
                        locked_d      = 1'b0;
                        fault_d       = 1'b1;
                        fault_cause_d = C_CAUSE_TIMEOUT;
                        w_err_event   = 1'b1;
                    end
                end
                S_FAULT: begin
                    // The fault is already latched, so further bad periods
                    // are not counted again while waiting for clr_fault.
                    if (clr_fault) begin
                        state_d       = S_SYNC;
                        fault_d       = 1'b0;
                        fault_cause_d = 2'b00;
                        good_cnt_d    = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (w_err_event && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            div_q          <= 1'b0;
            cnt_q          <= '0;
            hcnt_q         <= '0;
            good_cnt_q     <= '0;
            period_meas_q  <= '0;
            high_meas_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            fault_q        <= 1'b0;
            fault_cause_q  <= 2'b00;
            err_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_in;
            cnt_q          <= cnt_d;
            hcnt_q         <= hcnt_d;
            good_cnt_q     <= good_cnt_d;
            period_meas_q  <= period_meas_d;
            high_meas_q    <= high_meas_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            fault_q        <= fault_d;
            fault_cause_q  <= fault_cause_d;
            err_count_q    <= err_count_d;
        end
    end

    assign period_meas  = period_meas_q;
    assign high_meas    = high_meas_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign fault_cause  = fault_cause_q;
    assign err_count    = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_monitor
// Description : Self-checking bench for clk_div_monitor. Directed period
//               tables with fixed expectations, hand-written corner-case
//               sequences, and random div_in/en/clr_fault traffic compared
//               every cycle against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_monitor;

    localparam int N        = 4;
    localparam int TOL      = 0;
    localparam int LOCK_CNT = 4;
    localparam int CW       = 16;
    localparam int TMO      = 2 * N + TOL + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr_fault;
    logic          div_in;
    logic [CW-1:0] period_meas;
    logic [CW-1:0] high_meas;
    logic          period_valid;
    logic          locked;
    logic          fault;
    logic [1:0]    fault_cause;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    clk_div_monitor #(
        .N        (N),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT),
        .CW       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr_fault    (clr_fault),
        .div_in       (div_in),
        .period_meas  (period_meas),
        .high_meas    (high_meas),
        .period_valid (period_valid),
        .locked       (locked),
        .fault        (fault),
        .fault_cause  (fault_cause),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: periods are measured as the distance in cycles
    // between timestamps of successive rises (or timeout restarts).
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_SYNC, M_MEAS, M_LOCK, M_FAULT} mstate_t;
    mstate_t m_state;
    longint  m_cyc;
    longint  m_anchor;
    int      m_high;
    int      m_good;
    bit      m_prev;
    bit      e_valid, e_locked, e_fault;
    int      e_period, e_high, e_cause, e_err;

    task automatic model_reset();
        m_state  = M_IDLE;
        m_anchor = m_cyc;
        m_high   = 0;
        m_good   = 0;
        m_prev   = 1'b0;
        e_valid  = 1'b0;
        e_locked = 1'b0;
        e_fault  = 1'b0;
        e_period = 0;
        e_high   = 0;
        e_cause  = 0;
        e_err    = 0;
    endtask

    task automatic model_step(input bit i_en, input bit i_clr, input bit i_div);
        bit     rise, tmo, good, err_ev;
        longint elapsed;
        rise    = i_div && !m_prev;
        elapsed = m_cyc - m_anchor;
        e_valid = 1'b0;
        err_ev  = 1'b0;
        if (!i_en) begin
            m_state  = M_IDLE;
            e_locked = 1'b0;
            e_fault  = 1'b0;
            e_cause  = 0;
            m_good   = 0;
            m_high   = 0;
            m_anchor = m_cyc + 1;
        end else if (m_state == M_IDLE) begin
            m_state  = M_SYNC;
            m_high   = 0;
            m_anchor = m_cyc + 1;
        end else begin
            tmo  = !rise && (elapsed == TMO);
            good = (elapsed >= N - TOL) && (elapsed <= N + TOL);
            if (rise && m_state != M_SYNC) begin
                e_valid  = 1'b1;
                e_period = int'(elapsed);
                e_high   = m_high;
            end
            case (m_state)
                M_SYNC: begin
                    if (rise) m_state = M_MEAS;
                    else if (tmo) err_ev = 1'b1;
                end
                M_MEAS: begin
                    if (rise && good) begin
                        m_good++;
                        if (m_good == LOCK_CNT) begin
                            m_state  = M_LOCK;
                            e_locked = 1'b1;
                        end
                    end else if (rise || tmo) begin
                        m_good = 0;
                        err_ev = 1'b1;
                    end
                end
                M_LOCK: begin
                    if ((rise && !good) || tmo) begin
                        m_state  = M_FAULT;
                        e_locked = 1'b0;
                        e_fault  = 1'b1;
                        e_cause  = rise ? 1 : 2;
                        err_ev   = 1'b1;
                    end
                end
                M_FAULT: begin
                    if (i_clr) begin
                        m_state = M_SYNC;
                        e_fault = 1'b0;
                        e_cause = 0;
                        m_good  = 0;
                    end
                end
                default: ;
            endcase
            if (rise || tmo) m_anchor = m_cyc;
            if (rise) m_high = 1;
            else if (i_div) m_high++;
            if (err_ev && e_err < 255) e_err++;
        end
        m_prev = i_div;
        m_cyc++;
    endtask

    task automatic check_all(input string tag);
        checks++;
        if (period_valid !== e_valid || locked !== e_locked || fault !== e_fault ||
            fault_cause !== 2'(e_cause) || err_count !== 8'(e_err) ||
            period_meas !== CW'(e_period) || high_meas !== CW'(e_high)) begin
            errors++;
            $display("FAIL %s t=%0t actual v=%0b p=%0d h=%0d l=%0b f=%0b c=%0d e=%0d required v=%0b p=%0d h=%0d l=%0b f=%0b c=%0d e=%0d",
                     tag, $time, period_valid, period_meas, high_meas, locked, fault,
                     fault_cause, err_count, e_valid, e_period, e_high, e_locked,
                     e_fault, e_cause, e_err);
        end
    endtask

    // One clock: model and DUT see the same inputs, outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        model_step(en, clr_fault, div_in);
        #1;
        check_all("model");
    endtask

    // ------------------------------------------------------------------
    // Directed vectors. Each record drives one div_in period (hi then lo
    // cycles). When chk is set, the expected outputs are compared right
    // after the rise that opens this record, i.e. they describe the
    // measurement of the previous record's period.
    // ------------------------------------------------------------------
    typedef struct {
        int hi;
        int lo;
        bit chk;
        bit valid;
        int period;
        int high;
        bit lck;
        bit flt;
        int cause;
        int err;
    } vec_t;

    vec_t lock_tab[8];
    vec_t rec_tab[5];
    vec_t meas_tab[9];
    vec_t v;

    task automatic check_vec(input string name, input vec_t x);
        checks++;
        if (period_valid !== x.valid || period_meas !== CW'(x.period) ||
            high_meas !== CW'(x.high) || locked !== x.lck || fault !== x.flt ||
            fault_cause !== 2'(x.cause) || err_count !== 8'(x.err)) begin
            errors++;
            $display("FAIL %s actual v=%0b p=%0d h=%0d l=%0b f=%0b c=%0d e=%0d required v=%0b p=%0d h=%0d l=%0b f=%0b c=%0d e=%0d",
                     name, period_valid, period_meas, high_meas, locked, fault,
                     fault_cause, err_count, x.valid, x.period, x.high, x.lck,
                     x.flt, x.cause, x.err);
        end
    endtask

    task automatic drive_period(input string name, input vec_t x);
        for (int k = 0; k < x.hi + x.lo; k++) begin
            div_in = (k < x.hi);
            tick();
            if (k == 0 && x.chk) check_vec(name, x);
        end
    endtask

    task automatic hold_low(input int n);
        for (int k = 0; k < n; k++) begin
            div_in = 1'b0;
            tick();
        end
    endtask

    int hi, lo, sel;

    initial begin
        //                 hi lo chk v  per hi lck flt c  err
        lock_tab[0] = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        lock_tab[1] = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 0};
        lock_tab[2] = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 0};
        lock_tab[3] = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 0};
        lock_tab[4] = '{2, 2, 1, 1, 4, 2, 1, 0, 0, 0};
        lock_tab[5] = '{3, 2, 1, 1, 4, 2, 1, 0, 0, 0};
        lock_tab[6] = '{2, 2, 1, 1, 5, 3, 0, 1, 1, 1};
        lock_tab[7] = '{2, 2, 1, 1, 4, 2, 0, 1, 1, 1};

        rec_tab[0]  = '{2, 2, 1, 0, 4, 2, 0, 0, 0, 1};
        rec_tab[1]  = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 1};
        rec_tab[2]  = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 1};
        rec_tab[3]  = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 1};
        rec_tab[4]  = '{2, 2, 1, 1, 4, 2, 1, 0, 0, 1};

        meas_tab[0] = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        meas_tab[1] = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 2};
        meas_tab[2] = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 2};
        meas_tab[3] = '{2, 1, 1, 1, 4, 2, 0, 0, 0, 2};
        meas_tab[4] = '{2, 2, 1, 1, 3, 2, 0, 0, 0, 3};
        meas_tab[5] = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 3};
        meas_tab[6] = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 3};
        meas_tab[7] = '{2, 2, 1, 1, 4, 2, 0, 0, 0, 3};
        meas_tab[8] = '{2, 2, 1, 1, 4, 2, 1, 0, 0, 3};

        m_cyc     = 0;
        rst       = 1'b1;
        en        = 1'b0;
        clr_fault = 1'b0;
        div_in    = 1'b0;
        model_reset();

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        check_vec("reset", v);
        check_all("reset_model");
        rst = 1'b1;

        // Lock, then one 5-cycle period while locked
        en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) drive_period($sformatf("lock[%0d]", i), lock_tab[i]);

        // Clear the fault and relock; err_count must stay at 1
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        v = '{0, 0, 1, 0, 4, 2, 0, 0, 0, 1};
        check_vec("clr_fault", v);
        for (int i = 0; i < 5; i++) drive_period($sformatf("recover[%0d]", i), rec_tab[i]);

        // Stuck low while locked: timeout exactly TMO cycles after the last rise
        hold_low(TMO - 4);
        v = '{0, 0, 1, 0, 4, 2, 1, 0, 0, 1};
        check_vec("stuck_before", v);
        hold_low(1);
        v = '{0, 0, 1, 0, 4, 2, 0, 1, 2, 2};
        check_vec("stuck_timeout", v);

        // Relock, then drop en while locked
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = '{2, 2, (i == 4), 1, 4, 2, 1, 0, 0, 2};
            drive_period("relock", v);
        end
        en = 1'b0;
        tick();
        v = '{0, 0, 1, 0, 4, 2, 0, 0, 0, 2};
        check_vec("en_drop", v);
        tick();
        check_vec("en_hold", v);

        // Short period before lock restarts the good-period count
        en = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) drive_period($sformatf("meas[%0d]", i), meas_tab[i]);

        // Many bad periods in MEASURE: err_count saturates at 255
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        v = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        drive_period("sat_sync", v);
        for (int i = 0; i < 300; i++) begin
            v = '{2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
            drive_period("sat", v);
        end
        v = '{0, 0, 1, 0, 3, 2, 0, 0, 0, 255};
        check_vec("saturate", v);

        // Asynchronous reset in the middle of a cycle, while measuring
        v = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        drive_period("pre_reset", v);
        drive_period("pre_reset", v);
        #2 rst = 1'b0;
        #1;
        v = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        check_vec("async_reset", v);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;

        // Random traffic against the reference model
        for (int p = 0; p < 700; p++) begin
            sel = $urandom_range(0, 99);
            if (sel < 60) begin
                hi = $urandom_range(1, N - 1);
                lo = N - hi;
            end else if (sel < 90) begin
                hi = $urandom_range(1, N + 2);
                lo = $urandom_range(1, N + 2);
            end else begin
                hi = $urandom_range(1, 2);
                lo = $urandom_range(TMO - 2, TMO + 6);
            end
            for (int k = 0; k < hi + lo; k++) begin
                div_in    = (k < hi);
                en        = ($urandom_range(0, 299) != 0);
                clr_fault = ($urandom_range(0, 29) == 0);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Downstream consumer of the clock divider output (clk_out, divide factor N). Samples the divided clock as data in the source clk domain and measures its period and high time in clk cycles.
- Declares lock after consecutive in-tolerance periods. Flags faults on bad periods or a stuck divided clock.
- Feeds status to control logic and the bench, so divider integrity is checked in-system.

Parameters:
- N, 4, expected divide factor (period of div_in in clk cycles); N >= 2.
- TOL, 0, allowed deviation |period - N| in clk cycles.
- LOCK_CNT, 4, consecutive good periods required to lock; 1..15.
- CW, 16, width of the measurement counters; 2^CW > 2*N+TOL+1.

Ports:
- clk  input  1  source clock, the same clock that drives the divider.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  monitor enable; low forces IDLE.
- clr_fault  input  1  single-cycle pulse; leaves FAULT.
- div_in  input  1  divided clock (divider clk_out), synchronous to clk.
- period_meas  output  CW  last measured period, in clk cycles.
- high_meas  output  CW  high cycles in the last measured period.
- period_valid  output  1  one-cycle pulse when period_meas/high_meas update.
- locked  output  1  lock status.
- fault  output  1  sticky fault status.
- fault_cause  output  2  01 = period out of tolerance, 10 = timeout (stuck div_in).
- err_count  output  8  saturating count of bad-period and timeout events.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0. Internal div_q, cnt, hcnt and good_cnt are 0.
- Edge detect: rise = div_in & ~div_q, where div_q is div_in registered.
- cnt:
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1.
- hcnt:
  - On rise: hcnt <= 1.
  - Otherwise, when div_in=1: hcnt <= hcnt+1.
  - Otherwise: hold.
- Measurement: on rise in MEASURE or LOCKED, period_meas <= cnt, high_meas <= hcnt and period_valid <= 1, all registered. The outputs are visible the cycle after the rise cycle.
  - Example, N=4 with 2 high / 2 low: period_meas=4, high_meas=2.
- Good period: |cnt - N| <= TOL at the rise. Compute with CW+1-bit signed arithmetic.
- Timeout: cnt == 2*N+TOL+1 with no rise. Effect: cnt <= 1, no period_valid. Applies in SYNC, MEASURE and LOCKED.
- States:
  - IDLE: stays while en=0. en=1 -> SYNC.
  - SYNC: first rise -> MEASURE. No measurement is reported from this edge. Timeout -> err_count++, stay in SYNC.
  - MEASURE: on a good period, good_cnt++. When good_cnt reaches LOCK_CNT -> LOCKED, and locked=1 in the same cycle as that period_valid. On a bad period or timeout: good_cnt <= 0, err_count++, stay in MEASURE.
  - LOCKED: a good period holds the state.
    - Bad period -> FAULT, fault_cause=01.
    - Timeout -> FAULT, fault_cause=10.
    - In both cases err_count++ and locked<=0.
  - FAULT: fault=1, locked=0, measurements continue. clr_fault=1 -> SYNC with fault, fault_cause and good_cnt cleared; err_count is kept.
- en=0 in any state -> IDLE on the next edge. Clears locked, fault, fault_cause, good_cnt, cnt and hcnt. err_count and period_meas are held.
- Priority: en=0 > clr_fault > fault event > good period.
- A rise and a timeout in the same cycle count as a rise, so a period of exactly 2*N+TOL+1 is measured as a bad period, not a timeout.
- err_count saturates at 255 and does not wrap.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Lock: N=4, TOL=0, LOCK_CNT=4, en=1, div_in = ideal divide-by-4 (2H/2L) -> period_valid every 4 clks, period_meas=4, high_meas=2, locked=1 with the 4th valid pulse, err_count=0.
- Bad period in LOCKED: insert one 5-cycle period (3H/2L) -> period_meas=5, fault=1, fault_cause=01, locked=0, err_count=1.
- Stuck clock in LOCKED: hold div_in=0 -> timeout 9 cycles after the last rise, fault=1, fault_cause=10, no period_valid.
- Recovery: after a fault, pulse clr_fault, then resume the ideal div_in -> SYNC; locked=1 again after 1 sync edge plus 4 good periods; err_count is unchanged.
- MEASURE error: 3-cycle period before lock -> good_cnt restarts and lock is delayed by 4 further good periods; 300 bad periods -> err_count=255.
- Reset/enable: drop rst mid-MEASURE -> all outputs 0 immediately, without waiting for a clk edge. Drop en while LOCKED -> locked=0 on the next cycle and err_count is held.
